burst_ram_arbiter: RTL and testbench
====================================

BURST_RAM_ARBITER -- requirements
Module: burst_ram_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH_BITWIDTH, default 8, meaning the width of the BurstRAM address.
REQ-002 The block SHALL have parameter DATA_BITWIDTH, default 64, meaning the width of one burst data word.
REQ-003 The block SHALL have parameter BURST_COUNT, default 4, meaning the number of data words per burst.
REQ-004 clk  in  1  sole clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cN_req  in  1  (N=0,1) client N requests ownership of BurstRAM.
REQ-007 cN_gnt  out  1  client N owns BurstRAM; driven from a register.
REQ-008 cN_cmd  in  1  command from client N: 1=write, 0=read.
REQ-009 cN_cmd_en  in  1  client N issues a command.
REQ-010 cN_addr  in  DEPTH_BITWIDTH  burst address from client N.
REQ-011 cN_wr_data  in  DATA_BITWIDTH  write data from client N.
REQ-012 cN_data_mask  in  DATA_BITWIDTH/8  byte mask from client N.
REQ-013 cN_rd_data  out  DATA_BITWIDTH  read data to client N, equal to br_rd_data.
REQ-014 cN_rd_data_valid  out  1  br_rd_data_valid gated by cN_gnt.
REQ-015 cN_busy  out  1  br_busy while granted; 1 otherwise.
REQ-016 br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  widths as for the cN_ signals  connect to BurstRAM.
REQ-017 br_rd_data, br_rd_data_valid, br_busy  in  widths as for the cN_ signals  connect from BurstRAM.

Function
REQ-018 The FSM SHALL have the states IDLE, OWNED, WRITE, READ and RELEASE.
REQ-019 In IDLE with br_busy=0 and at least one request, the block SHALL grant the winner: gnt rises on the next edge and the state becomes OWNED.
REQ-020 Arbitration SHALL be round-robin: when both clients request, the client that was not granted last wins; priority after reset is client 0.
REQ-021 While granted, the block SHALL forward the granted client's cmd, addr, wr_data and data_mask combinationally to br_*; the other client's inputs SHALL be ignored.
REQ-022 br_cmd_en SHALL equal the granted client's cmd_en in OWNED and WRITE, and 0 in every other state.
REQ-023 In OWNED, cmd_en=1 with cmd=1 SHALL count as write word 1 and move the FSM to WRITE; the word counter becomes 1.
REQ-024 In WRITE, the counter SHALL increment every cycle; after word BURST_COUNT the FSM SHALL go to RELEASE.
REQ-025 In OWNED, cmd_en=1 with cmd=0 SHALL move the FSM to READ with the counter at 0.
REQ-026 In READ, the counter SHALL count br_rd_data_valid pulses; the pulse that makes the count BURST_COUNT SHALL move the FSM to RELEASE.
REQ-027 Only one command is allowed per grant: cmd_en in READ or RELEASE SHALL be blocked from br_cmd_en.
REQ-028 In OWNED, if the client deasserts req without issuing a command, the FSM SHALL go to RELEASE.
REQ-029 In RELEASE, gnt SHALL be 0 for one cycle, the round-robin pointer SHALL update, and the FSM SHALL return to IDLE.
REQ-030 The minimum re-grant gap SHALL be two cycles after the last burst word (RELEASE, then IDLE).
REQ-031 cN_gnt SHALL be one-hot or zero at all times.
REQ-032 The counter SHALL be $clog2(BURST_COUNT)+1 bits wide and SHALL NOT wrap within a burst.
REQ-033 In IDLE, while br_busy=1, no grant SHALL be issued.

Reset
REQ-034 While rst=0, the block SHALL hold: state IDLE, both cN_gnt=0, counter 0, pointer at client 0, br_cmd_en=0, both cN_busy=1 and both cN_rd_data_valid=0.
REQ-035 Reset asserted mid-burst SHALL abort the burst immediately; read data still arriving from BurstRAM SHALL NOT be presented as valid to either client.
REQ-036 The first grant after rst rises SHALL follow REQ-019 and REQ-020.

Verification (BURST_COUNT=4, 3 cycles to data valid)
REQ-037 Reset release with c0_req=1 -> c0_gnt=1 one edge after IDLE is sampled with br_busy=0; c1_gnt=0.
REQ-038 c0 writes 4 words 0x11..0x44 at addr 0x10 -> 4 consecutive br_cmd_en/data cycles, RELEASE, c0_gnt=0.
REQ-039 c1 reads addr 0x10 -> c1_rd_data_valid pulses 4 times with 0x11..0x44; c0_rd_data_valid stays 0.
REQ-040 c0_req and c1_req rise in the same cycle after c1 was last granted -> c0 is granted first and c1 after RELEASE+IDLE; grants never overlap.
REQ-041 rst asserted during the second read beat -> gnt=0 and br_cmd_en=0 at once; no further valid pulses reach the clients.
REQ-042 Granted client drops req without a command -> RELEASE, then the other requester is granted.

Source files
------------

// File: rtl/burst_ram_arbiter.sv
// Two-client round-robin arbiter in front of a single BurstRAM port.
// One command (a write or read burst) per grant, then a one-cycle release gap.
module burst_ram_arbiter #(
    parameter int unsigned DEPTH_BITWIDTH = 8,
    parameter int unsigned DATA_BITWIDTH  = 64,
    parameter int unsigned BURST_COUNT    = 4
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        c0_req,
    output logic                        c0_gnt,
    input  logic                        c0_cmd,
    input  logic                        c0_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]   c0_addr,
    input  logic [DATA_BITWIDTH-1:0]    c0_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]  c0_data_mask,
    output logic [DATA_BITWIDTH-1:0]    c0_rd_data,
    output logic                        c0_rd_data_valid,
    output logic                        c0_busy,

    input  logic                        c1_req,
    output logic                        c1_gnt,
    input  logic                        c1_cmd,
    input  logic                        c1_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]   c1_addr,
    input  logic [DATA_BITWIDTH-1:0]    c1_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]  c1_data_mask,
    output logic [DATA_BITWIDTH-1:0]    c1_rd_data,
    output logic                        c1_rd_data_valid,
    output logic                        c1_busy,

    output logic                        br_cmd,
    output logic                        br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]   br_addr,
    output logic [DATA_BITWIDTH-1:0]    br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0]  br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]    br_rd_data,
    input  logic                        br_rd_data_valid,
    input  logic                        br_busy
);

    localparam int unsigned CNT_W = $clog2(BURST_COUNT) + 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_COUNT);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OWNED   = 3'd1,
        WRITE   = 3'd2,
        READ    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic             owner, owner_nxt;
    logic             ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       gnt, gnt_nxt;

    logic sel_req, sel_cmd, sel_cmd_en, granted;

    // Owner's control inputs; the non-owner is never looked at
    assign sel_req    = owner ? c1_req    : c0_req;
    assign sel_cmd    = owner ? c1_cmd    : c0_cmd;
    assign sel_cmd_en = owner ? c1_cmd_en : c0_cmd_en;
    assign granted    = |gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            owner <= 1'b0;
            ptr   <= 1'b0;
            cnt   <= '0;
            gnt   <= 2'b00;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = 2'b00;

        case (state)
            IDLE: begin
                if (!br_busy && (c0_req || c1_req)) begin
                    owner_nxt = (c0_req && c1_req) ? ptr : c1_req;
                    cnt_nxt   = '0;
                    state_nxt = OWNED;
                end
            end
            OWNED: begin
                if (sel_cmd_en) begin
                    if (sel_cmd) begin
                        cnt_nxt   = ONE;
                        state_nxt = (LAST_WORD <= ONE) ? RELEASE : WRITE;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = READ;
                    end
                end else if (!sel_req) begin
                    state_nxt = RELEASE;
                end
            end
            WRITE: begin
                cnt_nxt = cnt + ONE;
                if (cnt + ONE == LAST_WORD) begin
                    state_nxt = RELEASE;
                end
            end
            READ: begin
                if (br_rd_data_valid) begin
                    cnt_nxt = cnt + ONE;
                    if (cnt + ONE == LAST_WORD) begin
                        state_nxt = RELEASE;
                    end
                end
            end
            RELEASE: begin
                ptr_nxt   = ~owner;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Grant register follows the next state so it drops on entry to RELEASE
        if (state_nxt == OWNED || state_nxt == WRITE || state_nxt == READ) begin
            gnt_nxt = owner_nxt ? 2'b10 : 2'b01;
        end
    end

    assign c0_gnt = gnt[0];
    assign c1_gnt = gnt[1];

    assign br_cmd_en    = ((state == OWNED) || (state == WRITE)) && sel_cmd_en;
    assign br_cmd       = granted && sel_cmd;
    assign br_addr      = granted ? (owner ? c1_addr      : c0_addr)      : '0;
    assign br_wr_data   = granted ? (owner ? c1_wr_data   : c0_wr_data)   : '0;
    assign br_data_mask = granted ? (owner ? c1_data_mask : c0_data_mask) : '0;

    assign c0_rd_data       = br_rd_data;
    assign c1_rd_data       = br_rd_data;
    assign c0_rd_data_valid = br_rd_data_valid && gnt[0];
    assign c1_rd_data_valid = br_rd_data_valid && gnt[1];
    assign c0_busy          = gnt[0] ? br_busy : 1'b1;
    assign c1_busy          = gnt[1] ? br_busy : 1'b1;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small BurstRAM model
// (4-word bursts, read data valid from the third cycle after the command).
module tb_burst_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        c0_req, c0_gnt, c0_cmd, c0_cmd_en, c0_rd_data_valid, c0_busy;
    logic [7:0]  c0_addr, c0_data_mask;
    logic [63:0] c0_wr_data, c0_rd_data;
    logic        c1_req, c1_gnt, c1_cmd, c1_cmd_en, c1_rd_data_valid, c1_busy;
    logic [7:0]  c1_addr, c1_data_mask;
    logic [63:0] c1_wr_data, c1_rd_data;
    logic        br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
    logic [7:0]  br_addr, br_data_mask;
    logic [63:0] br_wr_data, br_rd_data;

    int vectors    = 0;
    int miscompares = 0;

    burst_ram_arbiter #(
        .DEPTH_BITWIDTH(8),
        .DATA_BITWIDTH (64),
        .BURST_COUNT   (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .c0_req          (c0_req),
        .c0_gnt          (c0_gnt),
        .c0_cmd          (c0_cmd),
        .c0_cmd_en       (c0_cmd_en),
        .c0_addr         (c0_addr),
        .c0_wr_data      (c0_wr_data),
        .c0_data_mask    (c0_data_mask),
        .c0_rd_data      (c0_rd_data),
        .c0_rd_data_valid(c0_rd_data_valid),
        .c0_busy         (c0_busy),
        .c1_req          (c1_req),
        .c1_gnt          (c1_gnt),
        .c1_cmd          (c1_cmd),
        .c1_cmd_en       (c1_cmd_en),
        .c1_addr         (c1_addr),
        .c1_wr_data      (c1_wr_data),
        .c1_data_mask    (c1_data_mask),
        .c1_rd_data      (c1_rd_data),
        .c1_rd_data_valid(c1_rd_data_valid),
        .c1_busy         (c1_busy),
        .br_cmd          (br_cmd),
        .br_cmd_en       (br_cmd_en),
        .br_addr         (br_addr),
        .br_wr_data      (br_wr_data),
        .br_data_mask    (br_data_mask),
        .br_rd_data      (br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .br_busy         (br_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BurstRAM model: writes land word by word, reads return 4 words on timer 3..6
    logic [63:0] mem [0:1023];
    logic [1:0]  wr_idx   = 2'd0;
    int          rd_base  = 0;
    int          rd_timer = 0;

    always @(posedge clk) begin
        if (br_cmd_en && br_cmd) begin
            mem[int'(br_addr) * 4 + int'(wr_idx)] <= br_wr_data;
            wr_idx <= wr_idx + 2'd1;
        end
        if (br_cmd_en && !br_cmd) begin
            rd_base  <= int'(br_addr);
            rd_timer <= 1;
        end else if (rd_timer != 0) begin
            rd_timer <= (rd_timer == 6) ? 0 : rd_timer + 1;
        end
    end

    always_comb begin
        br_rd_data_valid = (rd_timer >= 3) && (rd_timer <= 6);
        br_rd_data       = br_rd_data_valid ? mem[rd_base * 4 + (rd_timer - 3)] : 64'd0;
    end

    task automatic test_reset();
        rst = 1'b0;
        c0_req = 1'b1; c0_cmd = 1'b1; c0_cmd_en = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({c1_gnt, c0_gnt} !== 2'b00) begin
            miscompares++; $display("FAIL reset_gnt: got %b, expected 00", {c1_gnt, c0_gnt});
        end
        vectors++;
        if (br_cmd_en !== 1'b0) begin
            miscompares++; $display("FAIL reset_cmd_en: got %b, expected 0", br_cmd_en);
        end
        vectors++;
        if ({c1_busy, c0_busy} !== 2'b11) begin
            miscompares++; $display("FAIL reset_busy: got %b, expected 11", {c1_busy, c0_busy});
        end
        vectors++;
        if ({c1_rd_data_valid, c0_rd_data_valid} !== 2'b00) begin
            miscompares++; $display("FAIL reset_valid: got %b, expected 00", {c1_rd_data_valid, c0_rd_data_valid});
        end
        c0_cmd = 1'b0; c0_cmd_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({c1_gnt, c0_gnt} !== 2'b01) begin
            miscompares++; $display("FAIL first_grant: got %b, expected 01", {c1_gnt, c0_gnt});
        end
    endtask

    task automatic test_write();
        logic [63:0] exp_data;
        c1_addr = 8'h77; c1_wr_data = 64'hDEAD; c1_data_mask = 8'h0F;
        c1_cmd = 1'b0; c1_cmd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_data = 64'(32'h11 * (k + 1));
            c0_cmd = 1'b1; c0_cmd_en = 1'b1; c0_addr = 8'h10;
            c0_wr_data = exp_data; c0_data_mask = 8'hFF;
            #1;
            vectors++;
            if ({c0_gnt, br_cmd_en, br_cmd, br_addr, br_data_mask, br_wr_data} !==
                {1'b1, 1'b1, 1'b1, 8'h10, 8'hFF, exp_data}) begin
                miscompares++;
                $display("FAIL write_word%0d: got gnt=%b en=%b cmd=%b addr=%h mask=%h data=%h, expected 1 1 1 10 ff %h",
                         k, c0_gnt, br_cmd_en, br_cmd, br_addr, br_data_mask, br_wr_data, exp_data);
            end
            @(negedge clk);
        end
        vectors++;
        if ({c1_gnt, c0_gnt} !== 2'b00) begin
            miscompares++; $display("FAIL write_release_gnt: got %b, expected 00", {c1_gnt, c0_gnt});
        end
        vectors++;
        if (br_cmd_en !== 1'b0) begin
            miscompares++; $display("FAIL write_release_cmd_en: got %b, expected 0", br_cmd_en);
        end
        c0_req = 1'b0; c0_cmd_en = 1'b0; c0_cmd = 1'b0;
        c1_cmd_en = 1'b0;
        @(negedge clk);
        vectors++;
        if ({c1_gnt, c0_gnt} !== 2'b00) begin
            miscompares++; $display("FAIL write_idle_gnt: got %b, expected 00", {c1_gnt, c0_gnt});
        end
    endtask

    task automatic test_read();
        int pulses;
        c1_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({c1_gnt, c0_gnt} !== 2'b10) begin
            miscompares++; $display("FAIL read_grant: got %b, expected 10", {c1_gnt, c0_gnt});
        end
        c1_cmd = 1'b0; c1_cmd_en = 1'b1; c1_addr = 8'h10;
        c0_cmd = 1'b1; c0_cmd_en = 1'b1; c0_addr = 8'h55;
        #1;
        vectors++;
        if ({br_cmd_en, br_cmd, br_addr} !== {1'b1, 1'b0, 8'h10}) begin
            miscompares++;
            $display("FAIL read_cmd: got en=%b cmd=%b addr=%h, expected 1 0 10", br_cmd_en, br_cmd, br_addr);
        end
        @(negedge clk);
        vectors++;
        if (br_cmd_en !== 1'b0) begin
            miscompares++; $display("FAIL read_second_cmd_blocked: got %b, expected 0", br_cmd_en);
        end
        c1_cmd_en = 1'b0; c0_cmd_en = 1'b0; c0_cmd = 1'b0;
        pulses = 0;
        for (int cyc = 0; cyc < 12 && pulses < 4; cyc++) begin
            vectors++;
            if (c0_rd_data_valid !== 1'b0) begin
                miscompares++; $display("FAIL read_c0_valid: got %b, expected 0", c0_rd_data_valid);
            end
            if (c1_rd_data_valid === 1'b1) begin
                vectors++;
                if (c1_rd_data !== 64'(32'h11 * (pulses + 1))) begin
                    miscompares++;
                    $display("FAIL read_data%0d: got %h, expected %h", pulses, c1_rd_data, 64'(32'h11 * (pulses + 1)));
                end
                pulses++;
            end
            if (pulses < 4) @(negedge clk);
        end
        vectors++;
        if (pulses != 4) begin
            miscompares++; $display("FAIL read_pulses: got %0d, expected 4", pulses);
        end
        c1_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({c1_gnt, c0_gnt, c1_rd_data_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL read_release: got gnt=%b valid=%b, expected 00 0", {c1_gnt, c0_gnt}, c1_rd_data_valid);
        end
        @(negedge clk);
    endtask

    // Also covers the granted client dropping req without a command
    task automatic test_back_to_back();
        logic [1:0] exp_gnt [4];
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b00; exp_gnt[2] = 2'b00; exp_gnt[3] = 2'b10;
        c0_req = 1'b1; c1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({c1_gnt, c0_gnt} !== exp_gnt[i]) begin
                miscompares++;
                $display("FAIL b2b_gnt_cycle%0d: got %b, expected %b", i, {c1_gnt, c0_gnt}, exp_gnt[i]);
            end
            if (i == 0) c0_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid_read();
        c1_cmd = 1'b0; c1_cmd_en = 1'b1; c1_addr = 8'h10;
        @(negedge clk);
        c1_cmd_en = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (c1_rd_data_valid !== 1'b1) begin
            miscompares++; $display("FAIL midrd_first_beat: got %b, expected 1", c1_rd_data_valid);
        end
        @(negedge clk);
        c1_cmd_en = 1'b1;
        rst = 1'b0;
        #1;
        vectors++;
        if ({c1_gnt, c0_gnt, br_cmd_en, c1_rd_data_valid, c0_rd_data_valid, c1_busy} !== 6'b000001) begin
            miscompares++;
            $display("FAIL midrd_abort: got gnt=%b en=%b valid=%b busy1=%b, expected 00 0 00 1",
                     {c1_gnt, c0_gnt}, br_cmd_en, {c1_rd_data_valid, c0_rd_data_valid}, c1_busy);
        end
        c1_cmd_en = 1'b0; c1_req = 1'b0; c0_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({c1_gnt, c0_gnt, c1_rd_data_valid, c0_rd_data_valid} !== 4'b0000) begin
                miscompares++;
                $display("FAIL midrd_after%0d: got gnt=%b valid=%b, expected 00 00",
                         i, {c1_gnt, c0_gnt}, {c1_rd_data_valid, c0_rd_data_valid});
            end
            @(negedge clk);
        end
    endtask

    // Held-off grant while BurstRAM is busy; priority back at client 0 after reset
    task automatic test_busy();
        br_busy = 1'b1; c0_req = 1'b1; c1_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({c1_gnt, c0_gnt} !== 2'b00) begin
                miscompares++; $display("FAIL busy_hold%0d: got %b, expected 00", i, {c1_gnt, c0_gnt});
            end
        end
        br_busy = 1'b0;
        @(negedge clk);
        vectors++;
        if ({c1_gnt, c0_gnt} !== 2'b01) begin
            miscompares++; $display("FAIL busy_then_grant: got %b, expected 01", {c1_gnt, c0_gnt});
        end
        br_busy = 1'b1;
        #1;
        vectors++;
        if ({c1_busy, c0_busy} !== 2'b11) begin
            miscompares++; $display("FAIL busy_fwd_hi: got %b, expected 11", {c1_busy, c0_busy});
        end
        br_busy = 1'b0;
        #1;
        vectors++;
        if ({c1_busy, c0_busy} !== 2'b10) begin
            miscompares++; $display("FAIL busy_fwd_lo: got %b, expected 10", {c1_busy, c0_busy});
        end
    endtask

    task automatic test_round_robin();
        c0_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({c1_gnt, c0_gnt} !== 2'b00) begin
            miscompares++; $display("FAIL rr_release: got %b, expected 00", {c1_gnt, c0_gnt});
        end
        c0_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({c1_gnt, c0_gnt} !== 2'b00) begin
            miscompares++; $display("FAIL rr_idle: got %b, expected 00", {c1_gnt, c0_gnt});
        end
        @(negedge clk);
        vectors++;
        if ({c1_gnt, c0_gnt} !== 2'b10) begin
            miscompares++; $display("FAIL rr_c1_wins: got %b, expected 10", {c1_gnt, c0_gnt});
        end
        c0_req = 1'b0; c1_req = 1'b0;
    endtask

    initial begin
        rst = 1'b0; br_busy = 1'b0;
        c0_req = 1'b0; c0_cmd = 1'b0; c0_cmd_en = 1'b0;
        c0_addr = 8'h00; c0_wr_data = 64'd0; c0_data_mask = 8'h00;
        c1_req = 1'b0; c1_cmd = 1'b0; c1_cmd_en = 1'b0;
        c1_addr = 8'h00; c1_wr_data = 64'd0; c1_data_mask = 8'h00;

        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_read();
        test_busy();
        test_round_robin();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
